// File: rtl/command_header_parser.sv
`timescale 1ns/1ps
// command_header_parser
//
// Parses a big-endian TPM2 command byte stream coming out of the host
// interface FIFO. The 10-byte header (tag, commandSize, commandCode) and up
// to four leading parameter bytes are collected in shadow registers. Once
// they are complete, the shadows are copied to the presentation registers
// and keyStart_n is pulsed low for the management module. Every byte after
// the header is passed straight through to the execution engine. The leading
// parameter bytes are forwarded as well as captured. Framing problems raise
// a one-cycle err_valid with a TPM response code. The rest of the host
// transaction is then discarded.
//
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   byte stream from the interface FIFO
//   tpm_cc         captured commandCode
//   cmd_param      [32] parameter bytes present, [31:0] first <=4 param bytes
//   cmd_tag        captured tag
//   cmd_size       captured commandSize
//   keyStart_n     active-low command strobe, KEYSTART_CYCLES clocks long
//   body_data/body_valid/body_ready     parameter bytes to execution engine
//   err_valid      one-cycle error pulse
//   err_rc         response code of the most recent error
module command_header_parser #(
    parameter int MAX_CMD_SIZE    = 4096,
    parameter int KEYSTART_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] tpm_cc,
    output logic [32:0] cmd_param,
    output logic [15:0] cmd_tag,
    output logic [31:0] cmd_size,
    output logic        keyStart_n,
    output logic [7:0]  body_data,
    output logic        body_valid,
    input  logic        body_ready,
    output logic        err_valid,
    output logic [31:0] err_rc
);

    localparam int CW = $clog2(MAX_CMD_SIZE + 1);
    localparam int SW = (KEYSTART_CYCLES > 1) ? $clog2(KEYSTART_CYCLES) : 1;
    localparam logic [SW-1:0] KS_LAST    = SW'(KEYSTART_CYCLES - 1);
    localparam logic [31:0] RC_BAD_TAG   = 32'h0000_001E;
    localparam logic [31:0] RC_CMD_SIZE  = 32'h0000_0142;
    localparam logic [15:0] TAG_NO_SESS  = 16'h8001;
    localparam logic [15:0] TAG_SESS     = 16'h8002;
    localparam logic [31:0] HDR_SIZE     = 32'd10;
    localparam logic [31:0] MAX_SIZE     = 32'(MAX_CMD_SIZE);
    // Index of the fourth (last captured) parameter byte.
    localparam logic [CW-1:0] LAST_PARAM_IDX = CW'(13);

    typedef enum logic [2:0] {
        S_HDR,
        S_PARAM,
        S_STROBE,
        S_BODY,
        S_DRAIN
    } state_t;

    state_t         state_reg;
    logic           active_reg;
    logic [CW-1:0]  cnt_reg;
    logic [SW-1:0]  strobe_cnt_reg;
    logic [15:0]    tag_sh_reg;
    logic [31:0]    size_sh_reg;
    logic [31:0]    code_sh_reg;
    logic [31:0]    param_sh_reg;

    logic [31:0]    tpm_cc_reg;
    logic [32:0]    cmd_param_reg;
    logic [15:0]    cmd_tag_reg;
    logic [31:0]    cmd_size_reg;
    logic           keystart_n_reg;
    logic           err_valid_reg;
    logic [31:0]    err_rc_reg;

    logic           ready_raw;
    logic           accept;
    logic [3:0]     hdr_idx;
    logic [15:0]    tag_next;
    logic [31:0]    size_next;
    logic [31:0]    code_next;
    logic [31:0]    param_next;
    logic [CW-1:0]  cnt_inc;
    logic           is_final;
    logic           tag_bad;
    logic           size_bad;
    logic [31:0]    strobe_code;
    logic [32:0]    strobe_param;

    // Header and drain states always take bytes; the forwarding states are
    // throttled directly by the downstream so nothing is ever buffered here.
    // active_reg keeps in_ready low while reset is held and for one cycle after.
    always_comb begin
        ready_raw = 1'b0;
        case (state_reg)
            S_HDR, S_DRAIN:  ready_raw = 1'b1;
            S_PARAM, S_BODY: ready_raw = body_ready;
            default:         ready_raw = 1'b0;
        endcase
    end

    assign in_ready   = active_reg & ready_raw;
    assign accept     = in_valid & in_ready;
    assign body_data  = in_data;
    assign body_valid = active_reg & in_valid &
                        ((state_reg == S_PARAM) || (state_reg == S_BODY));

    // Header fields with the current byte shifted in, so checks can be made
    // on the same cycle the completing byte arrives.
    assign hdr_idx    = cnt_reg[3:0];
    assign tag_next   = {tag_sh_reg[7:0], in_data};
    assign size_next  = {size_sh_reg[23:0], in_data};
    assign code_next  = {code_sh_reg[23:0], in_data};
    assign param_next = {param_sh_reg[23:0], in_data};
    assign cnt_inc    = cnt_reg + CW'(1);
    // Size has been range-checked before any state that uses this, so the
    // truncation to the counter width is lossless.
    assign is_final   = (cnt_inc == size_sh_reg[CW-1:0]);
    assign tag_bad    = (tag_next != TAG_NO_SESS) && (tag_next != TAG_SESS);
    assign size_bad   = (size_next < HDR_SIZE) || (size_next > MAX_SIZE);

    // A header-only command strobes straight from S_HDR with the code still
    // completing on the current byte and no parameters; otherwise the code is
    // already in its shadow and the current byte completes the parameters.
    assign strobe_code  = (state_reg == S_HDR) ? code_next : code_sh_reg;
    assign strobe_param = (state_reg == S_HDR) ? 33'd0 : {1'b1, param_next};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_HDR;
            active_reg     <= 1'b0;
            cnt_reg        <= '0;
            strobe_cnt_reg <= '0;
            tag_sh_reg     <= '0;
            size_sh_reg    <= '0;
            code_sh_reg    <= '0;
            param_sh_reg   <= '0;
            tpm_cc_reg     <= '0;
            cmd_param_reg  <= '0;
            cmd_tag_reg    <= '0;
            cmd_size_reg   <= '0;
            keystart_n_reg <= 1'b1;
            err_valid_reg  <= 1'b0;
            err_rc_reg     <= '0;
        end else begin
            active_reg    <= 1'b1;
            err_valid_reg <= 1'b0;
            case (state_reg)
                S_HDR: begin
                    if (accept) begin
                        cnt_reg      <= cnt_inc;
                        param_sh_reg <= '0;
                        if (hdr_idx < 4'd2)
                            tag_sh_reg <= tag_next;
                        else if (hdr_idx < 4'd6)
                            size_sh_reg <= size_next;
                        else
                            code_sh_reg <= code_next;

                        // Content errors win over in_last; if in_last came
                        // with the bad byte the transaction is already over.
                        if (hdr_idx == 4'd1 && tag_bad) begin
                            err_valid_reg <= 1'b1;
                            err_rc_reg    <= RC_BAD_TAG;
                            state_reg     <= in_last ? S_HDR : S_DRAIN;
                            cnt_reg       <= '0;
                        end else if (hdr_idx == 4'd5 && size_bad) begin
                            err_valid_reg <= 1'b1;
                            err_rc_reg    <= RC_CMD_SIZE;
                            state_reg     <= in_last ? S_HDR : S_DRAIN;
                            cnt_reg       <= '0;
                        end else if (hdr_idx == 4'd9 && size_sh_reg == HDR_SIZE) begin
                            // Header-only command: byte 9 is also the final byte.
                            if (in_last) begin
                                state_reg      <= S_STROBE;
                                strobe_cnt_reg <= '0;
                                keystart_n_reg <= 1'b0;
                                tpm_cc_reg     <= strobe_code;
                                cmd_param_reg  <= strobe_param;
                                cmd_tag_reg    <= tag_sh_reg;
                                cmd_size_reg   <= size_sh_reg;
                            end else begin
                                err_valid_reg <= 1'b1;
                                err_rc_reg    <= RC_CMD_SIZE;
                                state_reg     <= S_DRAIN;
                                cnt_reg       <= '0;
                            end
                        end else if (in_last) begin
                            err_valid_reg <= 1'b1;
                            err_rc_reg    <= RC_CMD_SIZE;
                            state_reg     <= S_HDR;
                            cnt_reg       <= '0;
                        end else if (hdr_idx == 4'd9) begin
                            state_reg <= S_PARAM;
                        end
                    end
                end

                S_PARAM: begin
                    if (accept) begin
                        cnt_reg      <= cnt_inc;
                        param_sh_reg <= param_next;
                        if (is_final) begin
                            if (in_last) begin
                                state_reg      <= S_STROBE;
                                strobe_cnt_reg <= '0;
                                keystart_n_reg <= 1'b0;
                                tpm_cc_reg     <= strobe_code;
                                cmd_param_reg  <= strobe_param;
                                cmd_tag_reg    <= tag_sh_reg;
                                cmd_size_reg   <= size_sh_reg;
                            end else begin
                                err_valid_reg <= 1'b1;
                                err_rc_reg    <= RC_CMD_SIZE;
                                state_reg     <= S_DRAIN;
                                cnt_reg       <= '0;
                            end
                        end else if (in_last) begin
                            err_valid_reg <= 1'b1;
                            err_rc_reg    <= RC_CMD_SIZE;
                            state_reg     <= S_HDR;
                            cnt_reg       <= '0;
                        end else if (cnt_reg == LAST_PARAM_IDX) begin
                            state_reg      <= S_STROBE;
                            strobe_cnt_reg <= '0;
                            keystart_n_reg <= 1'b0;
                            tpm_cc_reg     <= strobe_code;
                            cmd_param_reg  <= strobe_param;
                            cmd_tag_reg    <= tag_sh_reg;
                            cmd_size_reg   <= size_sh_reg;
                        end
                    end
                end

                S_STROBE: begin
                    if (strobe_cnt_reg == KS_LAST) begin
                        keystart_n_reg <= 1'b1;
                        if (cnt_reg != size_sh_reg[CW-1:0]) begin
                            state_reg <= S_BODY;
                        end else begin
                            state_reg <= S_HDR;
                            cnt_reg   <= '0;
                        end
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg + SW'(1);
                    end
                end

                S_BODY: begin
                    if (accept) begin
                        cnt_reg <= cnt_inc;
                        if (is_final) begin
                            if (!in_last) begin
                                err_valid_reg <= 1'b1;
                                err_rc_reg    <= RC_CMD_SIZE;
                                state_reg     <= S_DRAIN;
                            end else begin
                                state_reg <= S_HDR;
                            end
                            cnt_reg <= '0;
                        end else if (in_last) begin
                            err_valid_reg <= 1'b1;
                            err_rc_reg    <= RC_CMD_SIZE;
                            state_reg     <= S_HDR;
                            cnt_reg       <= '0;
                        end
                    end
                end

                S_DRAIN: begin
                    if (accept && in_last) begin
                        state_reg <= S_HDR;
                        cnt_reg   <= '0;
                    end
                end

                default: begin
                    state_reg <= S_HDR;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign tpm_cc     = tpm_cc_reg;
    assign cmd_param  = cmd_param_reg;
    assign cmd_tag    = cmd_tag_reg;
    assign cmd_size   = cmd_size_reg;
    assign keyStart_n = keystart_n_reg;
    assign err_valid  = err_valid_reg;
    assign err_rc     = err_rc_reg;

endmodule

// File: tb/tb_command_header_parser.sv
`timescale 1ns/1ps
// Directed bench for command_header_parser: well-formed commands, header-only
// command, bad tag, oversize, early in_last, downstream back-pressure with a
// missing in_last, and reset in the middle of a body.
module tb_command_header_parser;

    typedef logic [7:0] byte_q_t[$];

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] tpm_cc;
    logic [32:0] cmd_param;
    logic [15:0] cmd_tag;
    logic [31:0] cmd_size;
    logic        keyStart_n;
    logic [7:0]  body_data;
    logic        body_valid;
    logic        body_ready;
    logic        err_valid;
    logic [31:0] err_rc;

    int      n_checks = 0;
    int      n_pass   = 0;
    int      ks_total = 0;
    int      err_total = 0;
    byte_q_t body_q;
    bit      br_toggle = 1'b0;

    command_header_parser dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tpm_cc     (tpm_cc),
        .cmd_param  (cmd_param),
        .cmd_tag    (cmd_tag),
        .cmd_size   (cmd_size),
        .keyStart_n (keyStart_n),
        .body_data  (body_data),
        .body_valid (body_valid),
        .body_ready (body_ready),
        .err_valid  (err_valid),
        .err_rc     (err_rc)
    );

    always #5 clock = ~clock;

    // Running counts of strobe-low cycles and error-pulse cycles.
    always @(negedge clock) begin
        if (keyStart_n == 1'b0) ks_total++;
        if (err_valid == 1'b1) err_total++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_body(input string tag, input byte_q_t exp);
        check_val({tag, "_count"}, 64'(body_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < body_q.size(); i++)
            check_val($sformatf("%s_byte%0d", tag, i), 64'(body_q[i]), 64'(exp[i]));
    endtask

    // Offer one byte until accepted; any body transfer on the same edge is logged.
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit         acc = 1'b0;
        int         waited = 0;
        logic       bv;
        logic [7:0] bd;
        while (!acc && waited < 50) begin
            @(negedge clock);
            in_data    = d;
            in_valid   = 1'b1;
            in_last    = last;
            body_ready = br_toggle ? ~body_ready : 1'b1;
            #1;
            acc = in_ready;
            bv  = body_valid & body_ready;
            bd  = body_data;
            @(posedge clock);
            if (bv) body_q.push_back(bd);
            waited++;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_seq(input string name, input byte_q_t b, input bit last_end);
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], last_end && (i == b.size() - 1));
        $display("sent %s: %0d bytes, last=%0d", name, b.size(), last_end);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    int      ks0, e0;
    byte_q_t cmd;
    byte_q_t exp_body;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; body_ready = 1'b1;
        repeat (3) @(negedge clock);
        check_val("rst_in_ready",   64'(in_ready),   64'd0);
        check_val("rst_keyStart_n", 64'(keyStart_n), 64'd1);
        check_val("rst_body_valid", 64'(body_valid), 64'd0);
        check_val("rst_err_valid",  64'(err_valid),  64'd0);
        check_val("rst_tpm_cc",     64'(tpm_cc),     64'd0);
        check_val("rst_cmd_param",  64'(cmd_param),  64'd0);
        check_val("rst_err_rc",     64'(err_rc),     64'd0);
        reset = 1'b0;
        idle(2);

        // CLEAR: code 0x144, two zero parameter bytes.
        ks0 = ks_total; e0 = err_total; body_q.delete();
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
        send_seq("clear", cmd, 1'b1);
        @(negedge clock);
        check_val("clear_strobe_low", 64'(keyStart_n), 64'd0);
        check_val("clear_strobe_rdy", 64'(in_ready),   64'd0);
        idle(5);
        check_val("clear_tpm_cc",    64'(tpm_cc),    64'h144);
        check_val("clear_cmd_param", 64'(cmd_param), 64'h1_0000_0000);
        check_val("clear_cmd_tag",   64'(cmd_tag),   64'h8001);
        check_val("clear_cmd_size",  64'(cmd_size),  64'd12);
        check_val("clear_strobe_len", 64'(ks_total - ks0), 64'd2);
        check_val("clear_no_err",    64'(err_total - e0), 64'd0);
        exp_body = '{8'h00, 8'h00};
        check_body("clear_body", exp_body);

        // STATE: same with parameter 00 01.
        ks0 = ks_total; e0 = err_total; body_q.delete();
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h01};
        send_seq("state", cmd, 1'b1);
        idle(5);
        check_val("state_cmd_param",  64'(cmd_param), 64'h1_0000_0001);
        check_val("state_strobe_len", 64'(ks_total - ks0), 64'd2);
        exp_body = '{8'h00, 8'h01};
        check_body("state_body", exp_body);

        // Bad tag 0x8003: error right after byte 1, rest drained.
        ks0 = ks_total; e0 = err_total; body_q.delete();
        send_byte(8'h80, 1'b0);
        send_byte(8'h03, 1'b0);
        @(negedge clock);
        check_val("badtag_err_valid", 64'(err_valid), 64'd1);
        check_val("badtag_err_rc",    64'(err_rc),    64'h1E);
        cmd = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
        send_seq("badtag_rest", cmd, 1'b1);
        idle(5);
        check_val("badtag_err_pulses", 64'(err_total - e0), 64'd1);
        check_val("badtag_no_strobe",  64'(ks_total - ks0), 64'd0);
        check_val("badtag_tpm_cc_held", 64'(tpm_cc), 64'h144);
        exp_body = {};
        check_body("badtag_body", exp_body);

        // Oversize 0x2000: error after byte 5, drain, then a good command.
        ks0 = ks_total; e0 = err_total; body_q.delete();
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h20, 8'h00};
        send_seq("oversize_hdr", cmd, 1'b0);
        @(negedge clock);
        check_val("oversize_err_valid", 64'(err_valid), 64'd1);
        check_val("oversize_err_rc",    64'(err_rc),    64'h142);
        cmd = '{8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
        send_seq("oversize_rest", cmd, 1'b1);
        cmd = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h00, 8'h00, 8'h01, 8'h45, 8'hAA, 8'hBB, 8'hCC};
        send_seq("after_oversize", cmd, 1'b1);
        idle(5);
        check_val("after_ovs_tpm_cc",    64'(tpm_cc),    64'h145);
        check_val("after_ovs_cmd_param", 64'(cmd_param), 64'h1_00AA_BBCC);
        check_val("after_ovs_cmd_tag",   64'(cmd_tag),   64'h8002);
        check_val("after_ovs_cmd_size",  64'(cmd_size),  64'd13);
        check_val("after_ovs_strobes",   64'(ks_total - ks0), 64'd2);
        check_val("after_ovs_errs",      64'(err_total - e0), 64'd1);
        exp_body = '{8'hAA, 8'hBB, 8'hCC};
        check_body("after_ovs_body", exp_body);

        // in_last on header byte 3.
        ks0 = ks_total; e0 = err_total;
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00};
        send_seq("early_last", cmd, 1'b1);
        @(negedge clock);
        check_val("early_err_valid", 64'(err_valid), 64'd1);
        check_val("early_err_rc",    64'(err_rc),    64'h142);
        idle(3);
        check_val("early_no_strobe", 64'(ks_total - ks0), 64'd0);

        // Header-only command (size 10).
        ks0 = ks_total; e0 = err_total; body_q.delete();
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h43};
        send_seq("size10", cmd, 1'b1);
        idle(5);
        check_val("size10_tpm_cc",    64'(tpm_cc),    64'h143);
        check_val("size10_cmd_param", 64'(cmd_param), 64'd0);
        check_val("size10_cmd_size",  64'(cmd_size),  64'd10);
        check_val("size10_strobes",   64'(ks_total - ks0), 64'd2);
        check_val("size10_no_err",    64'(err_total - e0), 64'd0);
        exp_body = {};
        check_body("size10_body", exp_body);

        // Size 16 sent as 20 bytes under 50% back-pressure; byte 15 lacks in_last.
        ks0 = ks_total; e0 = err_total; body_q.delete();
        br_toggle = 1'b1;
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h7A,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        send_seq("bp_size16", cmd, 1'b1);
        br_toggle = 1'b0;
        idle(5);
        check_val("bp_tpm_cc",    64'(tpm_cc),    64'h17A);
        check_val("bp_cmd_param", 64'(cmd_param), 64'h1_1122_3344);
        check_val("bp_cmd_size",  64'(cmd_size),  64'd16);
        check_val("bp_strobes",   64'(ks_total - ks0), 64'd2);
        check_val("bp_errs",      64'(err_total - e0), 64'd1);
        check_val("bp_err_rc",    64'(err_rc),    64'h142);
        exp_body = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        check_body("bp_body", exp_body);

        // Reset while in the body of a size-20 command.
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h01, 8'h50,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_seq("partial_body", cmd, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("midrst_keyStart_n", 64'(keyStart_n), 64'd1);
        check_val("midrst_in_ready",   64'(in_ready),   64'd0);
        check_val("midrst_tpm_cc",     64'(tpm_cc),     64'd0);
        check_val("midrst_cmd_param",  64'(cmd_param),  64'd0);
        check_val("midrst_cmd_size",   64'(cmd_size),   64'd0);
        check_val("midrst_cmd_tag",    64'(cmd_tag),    64'd0);
        check_val("midrst_err_rc",     64'(err_rc),     64'd0);
        reset = 1'b0;
        idle(2);
        ks0 = ks_total; e0 = err_total; body_q.delete();
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
        send_seq("clear_after_reset", cmd, 1'b1);
        idle(5);
        check_val("postrst_tpm_cc",    64'(tpm_cc),    64'h144);
        check_val("postrst_cmd_param", 64'(cmd_param), 64'h1_0000_0000);
        check_val("postrst_cmd_size",  64'(cmd_size),  64'd12);
        check_val("postrst_strobes",   64'(ks_total - ks0), 64'd2);
        check_val("postrst_no_err",    64'(err_total - e0), 64'd0);
        exp_body = '{8'h00, 8'h00};
        check_body("postrst_body", exp_body);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
